// File: rtl/iot_teletype_pkg.sv
// Shared definitions for the teletype IOT device block.
// Holds the default device codes, the keyboard and printer function codes,
// the decoded IOT instruction layout and the two FSM state types.
package iot_teletype_pkg;

  // Default device codes (IR[8:3]).
  localparam logic [5:0] KBD_DEV_CODE = 6'o03;
  localparam logic [5:0] PRT_DEV_CODE = 6'o04;

  // Keyboard function codes (IR[2:0]).
  localparam logic [2:0] FN_KCF = 3'd0;  // clear keyboard flag
  localparam logic [2:0] FN_KSF = 3'd1;  // skip on keyboard flag
  localparam logic [2:0] FN_KCC = 3'd2;  // clear flag and AC
  localparam logic [2:0] FN_KRS = 3'd4;  // read keyboard buffer (static)
  localparam logic [2:0] FN_KRB = 3'd6;  // clear AC, read buffer, clear flag

  // Teleprinter function codes (IR[2:0]).
  localparam logic [2:0] FN_TFL = 3'd0;  // set printer flag
  localparam logic [2:0] FN_TSF = 3'd1;  // skip on printer flag
  localparam logic [2:0] FN_TCF = 3'd2;  // clear printer flag
  localparam logic [2:0] FN_TPC = 3'd4;  // load and print
  localparam logic [2:0] FN_TLS = 3'd6;  // clear flag, load and print

  // IR[8:0] split into device and function fields.
  typedef struct packed {
    logic [5:0] dev;
    logic [2:0] fn;
  } iot_op_t;

  typedef enum logic {
    IDLE,
    RESP
  } ctl_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SEND,
    P_WAIT
  } prt_state_t;

endpackage

// File: rtl/iot_teletype_if.sv
// IOT bus between the CPU controller (master) and an IOT device (slave).
//   iot_req  : one-cycle pulse, CPU executing an IOT
//   iot_op   : IR[8:0], device [8:3] and function [2:0]
//   dataout  : AC[7:0] from the CPU
//   datain   : data ORed into AC (valid only with iot_done)
//   skip     : CPU increments PC (valid only with iot_done)
//   clear_ac : CPU clears AC before the OR (valid only with iot_done)
//   iot_done : one-cycle response strobe
interface iot_teletype_if;
  import iot_teletype_pkg::*;

  logic       iot_req;
  iot_op_t    iot_op;
  logic [7:0] dataout;
  logic [7:0] datain;
  logic       skip;
  logic       clear_ac;
  logic       iot_done;

  modport master (
    output iot_req, iot_op, dataout,
    input  datain, skip, clear_ac, iot_done
  );

  modport slave (
    input  iot_req, iot_op, dataout,
    output datain, skip, clear_ac, iot_done
  );
endinterface

// File: rtl/iot_printer.sv
// Teleprinter output engine: character buffer, ready/valid send stage and
// the busy-delay counter that models the mechanical print time.
//   clock, reset : system clock, asynchronous active-high reset
//   load         : request to print load_data (ignored unless idle)
//   load_data    : character to print
//   prt_valid    : character available to the printer sink
//   prt_data     : character to the printer sink (the buffer contents)
//   prt_ready    : printer sink accepts the character
//   done         : one-cycle pulse when the print delay has elapsed
module iot_printer
  import iot_teletype_pkg::*;
#(
  parameter int PRINT_DELAY = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       prt_valid,
  output logic [7:0] prt_data,
  input  logic       prt_ready,
  output logic       done
);

  localparam int CW = $clog2(PRINT_DELAY) + 1;

  prt_state_t    state, state_next;
  logic [7:0]    tbuf;
  logic [CW-1:0] count;

  // NOTE: every register here updates with <= so all of them sample the
  // pre-edge values of each other; a blocking = would create ordering races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= P_IDLE;
      tbuf  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      // A load while busy is dropped: the current character must stay stable.
      if (state == P_IDLE && load) tbuf <= load_data;
      // The handshake cycle itself is the first busy cycle, hence the -1.
      if (state == P_SEND && prt_ready) count <= CW'(PRINT_DELAY - 1);
      else if (state == P_WAIT && count != '0) count <= count - 1'b1;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    prt_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      P_IDLE: if (load) state_next = P_SEND;
      P_SEND: begin
        prt_valid = 1'b1;
        if (prt_ready) state_next = P_WAIT;
      end
      P_WAIT: if (count == '0) begin
        done       = 1'b1;
        state_next = P_IDLE;
      end
      default: state_next = P_IDLE;
    endcase
  end

  assign prt_data = tbuf;

endmodule

// File: rtl/iot_teletype.sv
// Keyboard (device KBD_DEV) and teleprinter (device PRT_DEV) IOT device.
// Decodes IOT instructions, holds the keyboard/printer flags and buffers and
// answers the CPU one cycle after each iot_req.
//   clock, reset           : system clock, asynchronous active-high reset
//   bus                    : IOT bus, slave side
//   kbd_valid/data/ready   : keyboard character stream (into the block)
//   prt_valid/data/ready   : printer character stream (out of the block)
module iot_teletype
  import iot_teletype_pkg::*;
#(
  parameter int         PRINT_DELAY = 16,
  parameter logic [5:0] KBD_DEV     = KBD_DEV_CODE,
  parameter logic [5:0] PRT_DEV     = PRT_DEV_CODE
) (
  input  logic             clock,
  input  logic             reset,
  iot_teletype_if.slave    bus,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_data,
  output logic             kbd_ready,
  output logic             prt_valid,
  output logic [7:0]       prt_data,
  input  logic             prt_ready
);

  ctl_state_t ctl_state, ctl_next;
  iot_op_t    op_q;
  logic       kflag, pflag;
  logic [7:0] kbuf;

  logic resp, kbd_sel, prt_sel;
  logic kflag_clr, pflag_set_cmd, pflag_clr, prt_load, prt_done;

  // Control FSM: a single response cycle follows every accepted request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctl_state <= IDLE;
      op_q      <= '0;
    end else begin
      ctl_state <= ctl_next;
      if (ctl_state == IDLE && bus.iot_req) op_q <= bus.iot_op;
    end
  end

  always_comb begin
    ctl_next = ctl_state;
    case (ctl_state)
      IDLE:    if (bus.iot_req) ctl_next = RESP;
      RESP:    ctl_next = IDLE;  // a request arriving here is ignored
      default: ctl_next = IDLE;
    endcase
  end

  assign resp    = (ctl_state == RESP);
  assign kbd_sel = resp && (op_q.dev == KBD_DEV);
  assign prt_sel = resp && (op_q.dev == PRT_DEV);

  // Instruction decode. Responses are only non-zero in RESP; an unknown
  // device still gets iot_done but nothing else.
  always_comb begin
    bus.iot_done  = resp;
    bus.skip      = 1'b0;
    bus.clear_ac  = 1'b0;
    bus.datain    = '0;
    kflag_clr     = 1'b0;
    pflag_set_cmd = 1'b0;
    pflag_clr     = 1'b0;
    prt_load      = 1'b0;
    if (kbd_sel) begin
      case (op_q.fn)
        FN_KCF: kflag_clr = 1'b1;
        FN_KSF: bus.skip  = kflag;
        FN_KCC: begin
          kflag_clr    = 1'b1;
          bus.clear_ac = 1'b1;
        end
        FN_KRS: bus.datain = kbuf;
        FN_KRB: begin
          kflag_clr    = 1'b1;
          bus.clear_ac = 1'b1;
          bus.datain   = kbuf;
        end
        default: ;
      endcase
    end else if (prt_sel) begin
      case (op_q.fn)
        FN_TFL: pflag_set_cmd = 1'b1;
        FN_TSF: bus.skip      = pflag;
        FN_TCF: pflag_clr     = 1'b1;
        FN_TPC: prt_load      = 1'b1;
        FN_TLS: begin
          pflag_clr = 1'b1;
          prt_load  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Keyboard: one-character buffer, back-pressured by its own flag.
  assign kbd_ready = !kflag;

  // NOTE: the character buffers are reset along with the flags so that a
  // read straight after reset returns zero rather than stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kflag <= 1'b0;
      kbuf  <= '0;
    end else if (kbd_valid && kbd_ready) begin
      // A character arriving alongside a clear is kept rather than lost.
      kbuf  <= kbd_data;
      kflag <= 1'b1;
    end else if (kflag_clr) begin
      kflag <= 1'b0;
    end
  end

  // Printer flag: completion of a print outranks a clear in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          pflag <= 1'b0;
    else if (prt_done || pflag_set_cmd) pflag <= 1'b1;
    else if (pflag_clr)                 pflag <= 1'b0;
  end

  iot_printer #(
    .PRINT_DELAY (PRINT_DELAY)
  ) u_printer (
    .clock     (clock),
    .reset     (reset),
    .load      (prt_load),
    .load_data (bus.dataout),
    .prt_valid (prt_valid),
    .prt_data  (prt_data),
    .prt_ready (prt_ready),
    .done      (prt_done)
  );

endmodule

// File: tb/tb_iot_teletype.sv
// Directed bench for iot_teletype. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, away from the edge.
module tb_iot_teletype;
  import iot_teletype_pkg::*;

  localparam int PD = 16;

  logic       clock;
  logic       reset;
  logic       kbd_valid;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       prt_valid;
  logic [7:0] prt_data;
  logic       prt_ready;

  int checks;
  int errors;

  iot_teletype_if bus ();

  iot_teletype #(
    .PRINT_DELAY (PD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .kbd_ready (kbd_ready),
    .prt_valid (prt_valid),
    .prt_data  (prt_data),
    .prt_ready (prt_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one IOT; returns in the response cycle with dataout still held.
  task automatic do_iot(input logic [8:0] op, input logic [7:0] d);
    bus.iot_req = 1'b1;
    bus.iot_op  = op;
    bus.dataout = d;
    tick();
    bus.iot_req = 1'b0;
  endtask

  task automatic test_reset();
    kbd_valid = 1'b1; kbd_data = 8'h55;
    tick();
    kbd_valid = 1'b0;
    do_iot(9'o044, 8'h66);
    tick();                                   // printer now in P_SEND
    bus.iot_req = 1'b1; bus.iot_op = 9'o041;
    tick();                                   // control now in RESP
    bus.iot_req = 1'b0;
    checks++; if (prt_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_prt_valid: got %b want 1", prt_valid); end
    checks++; if (bus.iot_done !== 1'b1) begin errors++; $display("FAIL pre_reset_iot_done: got %b want 1", bus.iot_done); end
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_kbd_ready: got %b want 0", kbd_ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.iot_done !== 1'b0) begin errors++; $display("FAIL reset_iot_done: got %b want 0", bus.iot_done); end
    checks++; if (bus.skip !== 1'b0) begin errors++; $display("FAIL reset_skip: got %b want 0", bus.skip); end
    checks++; if (bus.clear_ac !== 1'b0) begin errors++; $display("FAIL reset_clear_ac: got %b want 0", bus.clear_ac); end
    checks++; if (bus.datain !== 8'h00) begin errors++; $display("FAIL reset_datain: got %h want 00", bus.datain); end
    checks++; if (prt_valid !== 1'b0) begin errors++; $display("FAIL reset_prt_valid: got %b want 0", prt_valid); end
    checks++; if (prt_data !== 8'h00) begin errors++; $display("FAIL reset_prt_data: got %h want 00", prt_data); end
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL reset_kbd_ready: got %b want 1", kbd_ready); end
    tick();
    reset = 1'b0;
    tick();
    do_iot(9'o031, 8'h00);
    checks++; if (bus.skip !== 1'b0) begin errors++; $display("FAIL reset_ksf_skip: got %b want 0", bus.skip); end
    tick();
    do_iot(9'o041, 8'h00);
    checks++; if (bus.skip !== 1'b0) begin errors++; $display("FAIL reset_tsf_skip: got %b want 0", bus.skip); end
    tick();
  endtask

  task automatic test_keyboard();
    kbd_valid = 1'b1; kbd_data = 8'h41;
    tick();
    kbd_valid = 1'b0;
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL kbd_ready_after_char: got %b want 0", kbd_ready); end
    bus.iot_req = 1'b1; bus.iot_op = 9'o031; bus.dataout = 8'h00;
    #1;
    checks++; if (bus.iot_done !== 1'b0) begin errors++; $display("FAIL ksf_done_same_cycle: got %b want 0", bus.iot_done); end
    tick();
    bus.iot_req = 1'b0;
    checks++; if (bus.iot_done !== 1'b1) begin errors++; $display("FAIL ksf_done: got %b want 1", bus.iot_done); end
    checks++; if (bus.skip !== 1'b1) begin errors++; $display("FAIL ksf_skip: got %b want 1", bus.skip); end
    checks++; if (bus.datain !== 8'h00) begin errors++; $display("FAIL ksf_datain: got %h want 00", bus.datain); end
    tick();
    checks++; if (bus.iot_done !== 1'b0 || bus.skip !== 1'b0) begin errors++; $display("FAIL idle_after_resp: done %b skip %b want 0 0", bus.iot_done, bus.skip); end
    do_iot(9'o036, 8'h00);
    checks++; if (bus.clear_ac !== 1'b1) begin errors++; $display("FAIL krb_clear_ac: got %b want 1", bus.clear_ac); end
    checks++; if (bus.datain !== 8'h41) begin errors++; $display("FAIL krb_datain: got %h want 41", bus.datain); end
    checks++; if (bus.skip !== 1'b0) begin errors++; $display("FAIL krb_skip: got %b want 0", bus.skip); end
    tick();
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL krb_kbd_ready: got %b want 1", kbd_ready); end
  endtask

  task automatic test_kbd_hold();
    kbd_valid = 1'b1; kbd_data = 8'h37;
    tick();
    kbd_data = 8'h42;                         // held valid while the flag is set
    repeat (3) tick();
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL hold_kbd_ready: got %b want 0", kbd_ready); end
    do_iot(9'o034, 8'h00);
    checks++; if (bus.datain !== 8'h37) begin errors++; $display("FAIL krs_old_char: got %h want 37", bus.datain); end
    checks++; if (bus.clear_ac !== 1'b0) begin errors++; $display("FAIL krs_clear_ac: got %b want 0", bus.clear_ac); end
    tick();
    do_iot(9'o030, 8'h00);
    checks++; if (bus.iot_done !== 1'b1 || bus.skip !== 1'b0 || bus.clear_ac !== 1'b0 || bus.datain !== 8'h00) begin
      errors++; $display("FAIL kcf_resp: done %b skip %b clr %b datain %h want 1 0 0 00", bus.iot_done, bus.skip, bus.clear_ac, bus.datain);
    end
    tick();
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kcf_kbd_ready: got %b want 1", kbd_ready); end
    tick();
    kbd_valid = 1'b0;
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL accept_42_ready: got %b want 0", kbd_ready); end
    do_iot(9'o034, 8'h00);
    checks++; if (bus.datain !== 8'h42) begin errors++; $display("FAIL krs_new_char: got %h want 42", bus.datain); end
    tick();
    do_iot(9'o032, 8'h00);
    checks++; if (bus.clear_ac !== 1'b1 || bus.datain !== 8'h00) begin errors++; $display("FAIL kcc_resp: clr %b datain %h want 1 00", bus.clear_ac, bus.datain); end
    tick();
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kcc_kbd_ready: got %b want 1", kbd_ready); end
  endtask

  task automatic test_printer();
    prt_ready = 1'b0;
    do_iot(9'o046, 8'h5A);
    checks++; if (bus.iot_done !== 1'b1 || bus.skip !== 1'b0) begin errors++; $display("FAIL tls_resp: done %b skip %b want 1 0", bus.iot_done, bus.skip); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (prt_valid !== 1'b1 || prt_data !== 8'h5A) begin
        errors++; $display("FAIL tls_send_%0d: valid %b data %h want 1 5a", i, prt_valid, prt_data);
      end
      if (i < 3) tick();
    end
    prt_ready = 1'b1;
    tick();                                   // handshake edge
    prt_ready = 1'b0;
    checks++; if (prt_valid !== 1'b0) begin errors++; $display("FAIL tls_valid_after_hs: got %b want 0", prt_valid); end
    repeat (PD - 2) tick();
    do_iot(9'o041, 8'h00);                    // response one cycle before the flag sets
    checks++; if (bus.skip !== 1'b0) begin errors++; $display("FAIL tsf_early: got %b want 0", bus.skip); end
    tick();
    do_iot(9'o041, 8'h00);
    checks++; if (bus.skip !== 1'b1) begin errors++; $display("FAIL tsf_done: got %b want 1", bus.skip); end
    tick();
  endtask

  task automatic test_printer_busy();
    do_iot(9'o042, 8'h00); tick();
    do_iot(9'o041, 8'h00);
    checks++; if (bus.skip !== 1'b0) begin errors++; $display("FAIL tcf_skip: got %b want 0", bus.skip); end
    tick();
    do_iot(9'o040, 8'h00); tick();
    do_iot(9'o041, 8'h00);
    checks++; if (bus.skip !== 1'b1) begin errors++; $display("FAIL tfl_skip: got %b want 1", bus.skip); end
    tick();
    do_iot(9'o042, 8'h00); tick();            // pflag back to 0
    do_iot(9'o044, 8'h77);
    tick();
    checks++; if (prt_valid !== 1'b1 || prt_data !== 8'h77) begin errors++; $display("FAIL tpc_send: valid %b data %h want 1 77", prt_valid, prt_data); end
    prt_ready = 1'b1;
    tick();                                   // handshake edge
    prt_ready = 1'b0;
    do_iot(9'o044, 8'h33);                    // printer busy: load dropped
    tick();
    checks++; if (prt_valid !== 1'b0 || prt_data !== 8'h77) begin errors++; $display("FAIL tpc_busy: valid %b data %h want 0 77", prt_valid, prt_data); end
    for (int i = 0; i < PD - 4; i++) begin
      tick();
      checks++; if (prt_valid !== 1'b0) begin errors++; $display("FAIL busy_valid_%0d: got %b want 0", i, prt_valid); end
    end
    do_iot(9'o042, 8'h00);                    // TCF lands on the completion edge
    checks++; if (bus.iot_done !== 1'b1) begin errors++; $display("FAIL tcf_race_done: got %b want 1", bus.iot_done); end
    tick();
    do_iot(9'o041, 8'h00);
    checks++; if (bus.skip !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", bus.skip); end
    tick();
    checks++; if (prt_valid !== 1'b0 || prt_data !== 8'h77) begin errors++; $display("FAIL no_second_print: valid %b data %h want 0 77", prt_valid, prt_data); end
  endtask

  task automatic test_unused_device();
    do_iot(9'o071, 8'hFF);
    checks++; if (bus.iot_done !== 1'b1) begin errors++; $display("FAIL unused_done: got %b want 1", bus.iot_done); end
    checks++; if (bus.skip !== 1'b0 || bus.clear_ac !== 1'b0 || bus.datain !== 8'h00) begin
      errors++; $display("FAIL unused_resp: skip %b clr %b datain %h want 0 0 00", bus.skip, bus.clear_ac, bus.datain);
    end
    tick();
    checks++; if (prt_valid !== 1'b0 || kbd_ready !== 1'b1) begin errors++; $display("FAIL unused_state: prt_valid %b kbd_ready %b want 0 1", prt_valid, kbd_ready); end
  endtask

  task automatic test_back_to_back();
    bus.iot_req = 1'b1; bus.iot_op = 9'o041; bus.dataout = 8'h00;
    tick();
    checks++; if (bus.iot_done !== 1'b1 || bus.skip !== 1'b1) begin errors++; $display("FAIL b2b_first: done %b skip %b want 1 1", bus.iot_done, bus.skip); end
    tick();                                   // second pulse seen in RESP
    bus.iot_req = 1'b0;
    checks++; if (bus.iot_done !== 1'b0 || bus.skip !== 1'b0) begin errors++; $display("FAIL b2b_second: done %b skip %b want 0 0", bus.iot_done, bus.skip); end
    tick();
    checks++; if (bus.iot_done !== 1'b0) begin errors++; $display("FAIL b2b_after: got %b want 0", bus.iot_done); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    kbd_valid   = 1'b0;
    kbd_data    = 8'h00;
    prt_ready   = 1'b0;
    bus.iot_req = 1'b0;
    bus.iot_op  = 9'o000;
    bus.dataout = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_keyboard();
    test_kbd_hold();
    test_printer();
    test_printer_busy();
    test_unused_device();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
